fixed_point_multiply: RTL and testbench

Pipelined sign-magnitude fixed-point multiplier for the 16-bit datapath of the Level-1 mult/add pipeline. It takes two sign-magnitude operands each cycle and returns their product in the same format. The product is truncated and saturated, with a fixed two-cycle latency. It feeds the downstream fixed-point adder stage.

---
 rtl/fixed_point_pkg.sv | 16 +
 rtl/fixed_point_multiply_if.sv | 22 ++
 rtl/fixed_point_mag_mult.sv | 21 ++
 rtl/fixed_point_multiply.sv | 53 +++++
 tb/tb_fixed_point_multiply.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fixed_point_pkg.sv
// Shared types and constants for the sign-magnitude fixed-point multiplier.
// Word format: sign (MSB) + MAG_W magnitude bits, FRAC of them fractional.
package fixed_point_pkg;

    localparam int BITSIZE = 16;
    localparam int FRAC    = 9;
    localparam int MAG_W   = BITSIZE - 1;

    localparam logic [MAG_W-1:0] MAG_MAX = {MAG_W{1'b1}};

    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } sm_t;

endpackage

// File: rtl/fixed_point_multiply_if.sv
// Operand/product bus for the fixed-point multiplier.
// master drives in_valid/A/B and receives out_valid/C; slave is the DUT side.
interface fixed_point_multiply_if;
    import fixed_point_pkg::*;

    logic               in_valid;
    logic [BITSIZE-1:0] A;
    logic [BITSIZE-1:0] B;
    logic               out_valid;
    logic [BITSIZE-1:0] C;

    modport master (
        output in_valid, A, B,
        input  out_valid, C
    );

    modport slave (
        input  in_valid, A, B,
        output out_valid, C
    );

endinterface

// File: rtl/fixed_point_mag_mult.sv
// Combinational magnitude multiply: a*b, shifted right by FRAC, saturated.
// Ports: a_mag_i, b_mag_i (MAG_W unsigned), p_mag_o (MAG_W unsigned).
module fixed_point_mag_mult
    import fixed_point_pkg::*;
(
    input  logic [MAG_W-1:0] a_mag_i,
    input  logic [MAG_W-1:0] b_mag_i,
    output logic [MAG_W-1:0] p_mag_o
);

    logic [2*MAG_W-1:0] prod;
    logic [2*MAG_W-1:0] shifted;
    logic               ovf;

    assign prod    = {{MAG_W{1'b0}}, a_mag_i} * {{MAG_W{1'b0}}, b_mag_i};
    // Plain right shift truncates toward zero on an unsigned magnitude.
    assign shifted = prod >> FRAC;
    assign ovf     = |shifted[2*MAG_W-1:MAG_W];
    assign p_mag_o = ovf ? MAG_MAX : shifted[MAG_W-1:0];

endmodule

// File: rtl/fixed_point_multiply.sv
// Two-stage pipelined sign-magnitude fixed-point multiplier.
// Ports: clk, rst_n (async, active-low), bus (slave: in_valid/A/B -> out_valid/C).
module fixed_point_multiply
    import fixed_point_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    fixed_point_multiply_if.slave        bus
);

    sm_t              a_q;
    sm_t              b_q;
    logic             v1_q;
    sm_t              c_q;
    sm_t              c_d;
    logic             v2_q;
    logic [MAG_W-1:0] mag;

    fixed_point_mag_mult u_mag (
        .a_mag_i (a_q.mag),
        .b_mag_i (b_q.mag),
        .p_mag_o (mag)
    );

    // A zero magnitude (including -0 inputs and underflow) never carries a sign.
    always_comb begin
        c_d      = '0;
        c_d.mag  = mag;
        c_d.sign = (mag != '0) && (a_q.sign ^ b_q.sign);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
            c_q  <= '0;
            v2_q <= 1'b0;
        end else begin
            a_q  <= bus.A;
            b_q  <= bus.B;
            v1_q <= bus.in_valid;
            v2_q <= v1_q;
            if (v1_q) begin
                c_q <= c_d;
            end
        end
    end

    assign bus.C         = c_q;
    assign bus.out_valid = v2_q;

endmodule

// File: tb/tb_fixed_point_multiply.sv
// Directed-vector bench for fixed_point_multiply.
// Each task drives one scenario and checks results inline.
module tb_fixed_point_multiply;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    fixed_point_multiply_if bus ();

    fixed_point_multiply dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int NV = 8;
    logic [15:0] va [NV] = '{16'h0100, 16'h4100, 16'hC100, 16'h0000,
                             16'h0000, 16'h8000, 16'h4100, 16'h0001};
    logic [15:0] vb [NV] = '{16'h0100, 16'h8100, 16'h8100, 16'h0100,
                             16'h0000, 16'h8100, 16'hC100, 16'h8001};
    logic [15:0] vc [NV] = '{16'h0080, 16'hA080, 16'h2080, 16'h0000,
                             16'h0000, 16'h0000, 16'hFFFF, 16'h0000};

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.A = 16'h4100;
        bus.B = 16'h4100;
        #12;
        n_total++;
        if (bus.C !== 16'h0000 || bus.out_valid !== 1'b0)
            $display("FAIL reset: C=%h ov=%b want C=0000 ov=0",
                     bus.C, bus.out_valid);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.A = va[i];
            bus.B = vb[i];
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.A = 16'h7FFF;
            bus.B = 16'h7FFF;
            n_total++;
            if (bus.out_valid !== 1'b0)
                $display("FAIL vec%0d early: ov=%b want 0", i, bus.out_valid);
            else n_pass++;
            @(posedge clk);
            #1;
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.C !== vc[i])
                $display("FAIL vec%0d %h*%h: C=%h ov=%b want C=%h ov=1",
                         i, va[i], vb[i], bus.C, bus.out_valid, vc[i]);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A = 16'h4100;
        bus.B = 16'h8100;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.A = 16'h0100;
        bus.B = 16'h0100;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (bus.out_valid !== 1'b0 || bus.C !== 16'hA080)
                $display("FAIL hold%0d: C=%h ov=%b want C=a080 ov=0",
                         k, bus.C, bus.out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j < 4) begin
                bus.in_valid = 1'b1;
                bus.A = va[j];
                bus.B = vb[j];
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            n_total++;
            if (j >= 1 && j <= 4) begin
                if (bus.out_valid !== 1'b1 || bus.C !== vc[j-1])
                    $display("FAIL b2b%0d: C=%h ov=%b want C=%h ov=1",
                             j, bus.C, bus.out_valid, vc[j-1]);
                else n_pass++;
            end else begin
                if (bus.out_valid !== 1'b0)
                    $display("FAIL b2b%0d idle: ov=%b want 0",
                             j, bus.out_valid);
                else n_pass++;
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A = 16'h4100;
        bus.B = 16'h8100;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.C !== 16'hA080)
            $display("FAIL midrst pre: C=%h ov=%b want C=a080 ov=1",
                     bus.C, bus.out_valid);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.C !== 16'h0000 || bus.out_valid !== 1'b0)
            $display("FAIL midrst async: C=%h ov=%b want C=0000 ov=0",
                     bus.C, bus.out_valid);
        else n_pass++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (bus.out_valid !== 1'b0 || bus.C !== 16'h0000)
                $display("FAIL midrst stale%0d: C=%h ov=%b want C=0000 ov=0",
                         k, bus.C, bus.out_valid);
            else n_pass++;
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A = 16'hC100;
        bus.B = 16'h8100;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n_total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL midrst early: ov=%b want 0", bus.out_valid);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.C !== 16'h2080)
            $display("FAIL midrst first: C=%h ov=%b want C=2080 ov=1",
                     bus.C, bus.out_valid);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_vectors();
        test_hold();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
